multicycle_control32: RTL

- Multi-cycle successor to the single-cycle MIPS control decoder: one FSM walks each instruction through FETCH/DECODE/EXEC/MEM/WB instead of asserting all controls in one cycle.
- Parametrised memory latency and MMIO window.
- Stalls on IO through a ready handshake.
- Sits between IFetch/Decoder/ALU/dmemory/MemOrIO in the CPU top; the datapath gates its register loads on this block's strobes.

---
 rtl/multicycle_control32_if.sv | 46 ++++
 rtl/multicycle_control32.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control32_if.sv
// Control bus between the multi-cycle controller and the datapath.
//   master : the controller (samples instruction fields/flags, drives strobes)
//   slave  : the datapath side (drives instruction fields/flags, obeys strobes)
// Inputs to the controller: opcode, function_opcode, alu_result_high, zero,
// io_ready. Outputs: state, ir_write, pc_write, pc_src, static decode fields,
// reg_write, mem/io strobes, memorio_to_reg, io_err.
interface multicycle_control32_if #(
   parameter int IO_HIGH_W = 22
);
   logic [5:0]           opcode;
   logic [5:0]           function_opcode;
   logic [IO_HIGH_W-1:0] alu_result_high;
   logic                 zero;
   logic                 io_ready;
   logic [2:0]           state;
   logic                 ir_write;
   logic                 pc_write;
   logic [1:0]           pc_src;
   logic                 reg_dst;
   logic                 alu_src;
   logic                 i_format;
   logic                 sftmd;
   logic                 jal;
   logic [1:0]           alu_op;
   logic                 reg_write;
   logic                 mem_read;
   logic                 mem_write;
   logic                 io_read;
   logic                 io_write;
   logic                 memorio_to_reg;
   logic                 io_err;

   modport master (
      input  opcode, function_opcode, alu_result_high, zero, io_ready,
      output state, ir_write, pc_write, pc_src, reg_dst, alu_src, i_format,
             sftmd, jal, alu_op, reg_write, mem_read, mem_write, io_read,
             io_write, memorio_to_reg, io_err
   );

   modport slave (
      output opcode, function_opcode, alu_result_high, zero, io_ready,
      input  state, ir_write, pc_write, pc_src, reg_dst, alu_src, i_format,
             sftmd, jal, alu_op, reg_write, mem_read, mem_write, io_read,
             io_write, memorio_to_reg, io_err
   );
endinterface

// File: rtl/multicycle_control32.sv
// Multi-cycle MIPS control unit: one FSM steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and emits per-state strobes for the datapath.
// Ports: clock (rising edge), reset (async, active-high),
//        bus (multicycle_control32_if.master, see the interface file).
// Optional feature: define IO_TIMEOUT_EN to abort IO accesses that see no
// io_ready within IO_TIMEOUT cycles and raise the sticky io_err flag.
//
//   state  | meaning
//   FETCH  | instruction memory read, MEM_LAT cycles; IR/PC load in last
//   DECODE | capture opcode/func into the decode registers
//   EXEC   | branch/jump resolution, pick MEM/WB/FETCH
//   MEM    | data memory (MEM_LAT cycles) or IO (until io_ready)
//   WB     | register file write
module multicycle_control32 #(
   parameter int                   MEM_LAT     = 1,
   parameter int                   IO_HIGH_W   = 22,
   parameter logic [IO_HIGH_W-1:0] IO_HIGH_VAL = 22'h3FFFFF,
   parameter int                   IO_TIMEOUT  = 255
) (
   input logic                    clock,
   input logic                    reset,
   multicycle_control32_if.master bus
);
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

   if (MEM_LAT < 1) begin : g_bad_mem_lat
      $error("MEM_LAT must be at least 1");
   end
   if (IO_TIMEOUT < 1) begin : g_bad_io_timeout
      $error("IO_TIMEOUT must be at least 1");
   end

   state_t           state_q, state_d;
   logic [LAT_W-1:0] lat_cnt;
   logic [5:0]       op_q, func_q;
   logic             is_io;
   logic             lat_done;

   logic r_format, i_fmt, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr;
   logic ir_wr, pc_wr, reg_wr, mem_rd, mem_wr, io_rd, io_wr;
   logic [1:0] pc_sel;

   assign r_format = (op_q == 6'b000000);
   assign i_fmt    = (op_q[5:3] == 3'b001);
   assign is_lw    = (op_q == 6'b100011);
   assign is_sw    = (op_q == 6'b101011);
   assign is_beq   = (op_q == 6'b000100);
   assign is_bne   = (op_q == 6'b000101);
   assign is_j     = (op_q == 6'b000010);
   assign is_jal   = (op_q == 6'b000011);
   assign is_jr    = r_format && (func_q == 6'b001000);

   assign lat_done = (lat_cnt == LAT_LAST);

`ifdef IO_TIMEOUT_EN
   localparam int TO_W = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(IO_TIMEOUT - 1);
   logic [TO_W-1:0] to_cnt;
   logic            io_err_q;
   logic            io_abort;
`endif

   // Strobes are forced low while reset is high so that a reset pulse
   // kills an in-flight access combinationally, not at the next edge.
   always_comb begin
      state_d = state_q;
      ir_wr   = 1'b0;
      pc_wr   = 1'b0;
      pc_sel  = 2'b00;
      reg_wr  = 1'b0;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      io_rd   = 1'b0;
      io_wr   = 1'b0;
`ifdef IO_TIMEOUT_EN
      io_abort = 1'b0;
`endif
      if (!reset) begin
         case (state_q)
            FETCH: begin
               if (lat_done) begin
                  ir_wr   = 1'b1;
                  pc_wr   = 1'b1;
                  state_d = DECODE;
               end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
               state_d = FETCH;
               if (is_beq) begin
                  pc_wr  = bus.zero;
                  pc_sel = 2'b01;
               end else if (is_bne) begin
                  pc_wr  = !bus.zero;
                  pc_sel = 2'b01;
               end else if (is_j || is_jal) begin
                  pc_wr  = 1'b1;
                  pc_sel = 2'b10;
                  if (is_jal) state_d = WB;
               end else if (is_jr) begin
                  pc_wr  = 1'b1;
                  pc_sel = 2'b11;
               end else if (is_lw || is_sw) begin
                  state_d = MEM;
               end else if (r_format || i_fmt) begin
                  state_d = WB;
               end
            end
            MEM: begin
               if (is_io) begin
                  io_rd = is_lw;
                  io_wr = is_sw;
                  if (bus.io_ready) begin
                     state_d = is_lw ? WB : FETCH;
                  end
`ifdef IO_TIMEOUT_EN
                  else if (to_cnt == TO_LAST) begin
                     io_abort = 1'b1;
                     state_d  = FETCH;
                  end
`endif
               end else begin
                  mem_rd = is_lw;
                  mem_wr = is_sw;
                  if (lat_done) state_d = is_lw ? WB : FETCH;
               end
            end
            WB: begin
               reg_wr  = 1'b1;
               state_d = FETCH;
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
         lat_cnt <= '0;
         op_q    <= '0;
         func_q  <= '0;
         is_io   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q) begin
            lat_cnt <= '0;
         end else if (!lat_done) begin
            lat_cnt <= lat_cnt + 1'b1;
         end
         if (state_q == DECODE) begin
            op_q   <= bus.opcode;
            func_q <= bus.function_opcode;
         end
         if ((state_q == EXEC) && (state_d == MEM)) begin
            is_io <= (bus.alu_result_high == IO_HIGH_VAL);
         end
      end
   end

`ifdef IO_TIMEOUT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         to_cnt   <= '0;
         io_err_q <= 1'b0;
      end else begin
         if ((state_q == MEM) && is_io && (state_d == MEM)) begin
            to_cnt <= to_cnt + 1'b1;
         end else begin
            to_cnt <= '0;
         end
         if (io_abort) io_err_q <= 1'b1;
      end
   end
   assign bus.io_err = io_err_q;
`else
   assign bus.io_err = 1'b0;
`endif

   assign bus.state          = state_q;
   assign bus.ir_write       = ir_wr;
   assign bus.pc_write       = pc_wr;
   assign bus.pc_src         = pc_sel;
   assign bus.reg_write      = reg_wr;
   assign bus.mem_read       = mem_rd;
   assign bus.mem_write      = mem_wr;
   assign bus.io_read        = io_rd;
   assign bus.io_write       = io_wr;
   assign bus.reg_dst        = r_format;
   assign bus.alu_src        = i_fmt || is_lw || is_sw;
   assign bus.i_format       = i_fmt;
   assign bus.sftmd          = r_format && (func_q[5:3] == 3'b000);
   assign bus.jal            = is_jal;
   assign bus.alu_op         = {r_format || i_fmt, is_beq || is_bne};
   assign bus.memorio_to_reg = is_lw;
endmodule
